// File: rtl/risc16_prog_loader_pkg.sv
// Shared definitions for the RiSC-16 program loader: default widths,
// loader FSM state encodings and the ISA opcode encodings.
package risc16_prog_loader_pkg;

    localparam int unsigned LDR_WORD_LENGTH = 16;
    localparam int unsigned LDR_ADDR_WIDTH  = 8;
    localparam int unsigned LDR_RST_CYCLES  = 4;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LOAD = 3'd1,
        LDR_FULL = 3'd2,
        LDR_BOOT = 3'd3,
        LDR_RUN  = 3'd4
    } ldr_state_t;

    // RiSC-16 major opcodes (instr[15:13])
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } risc16_opcode_t;

endpackage

// File: rtl/risc16_prog_loader_if.sv
// Programming port of the loader: program enable, word stream with
// valid/ready handshake and the load base address.
interface risc16_prog_loader_if
    import risc16_prog_loader_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = LDR_WORD_LENGTH,
    parameter int unsigned ADDR_WIDTH  = LDR_ADDR_WIDTH
);
    logic                   pen;
    logic [WORD_LENGTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [ADDR_WIDTH-1:0]  base_addr;

    modport master (
        output pen,
        output instr,
        output instr_valid,
        output base_addr,
        input  instr_ready
    );

    modport slave (
        input  pen,
        input  instr,
        input  instr_valid,
        input  base_addr,
        output instr_ready
    );

endinterface

// File: rtl/risc16_rst_stretch.sv
// Down-counter timing the core reset stretch after programming ends.
// zero_c is high once RST_CYCLES-1 decrements have elapsed since start.
module risc16_rst_stretch
    import risc16_prog_loader_pkg::*;
#(
    parameter int unsigned RST_CYCLES = LDR_RST_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic zero_c
);

    localparam int unsigned CW = $clog2(RST_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(RST_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/risc16_prog_loader.sv
// Program loader: streams words from the programming port into the
// instruction memory and sequences the RiSC-16 core reset around it.
module risc16_prog_loader
    import risc16_prog_loader_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = LDR_WORD_LENGTH,
    parameter int unsigned ADDR_WIDTH  = LDR_ADDR_WIDTH,
    parameter int unsigned RST_CYCLES  = LDR_RST_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    risc16_prog_loader_if.slave    prog,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [WORD_LENGTH-1:0] imem_wdata,
    output logic [ADDR_WIDTH:0]    word_count,
    output logic [WORD_LENGTH-1:0] checksum,
    output logic                   full,
    output logic                   overflow,
    output logic                   core_rst,
    output logic                   loading
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEPTH - 1);

    ldr_state_t            state;
    logic [ADDR_WIDTH-1:0] ptr;

    logic ready_c;
    logic xfer_c;
    logic load_entry_c;
    logic boot_start_c;
    logic stretch_zero_c;

    // Ready is combinational so a word is never taken in a pen-low cycle
    assign ready_c          = prog.pen && (state == LDR_LOAD);
    assign prog.instr_ready = ready_c;
    assign xfer_c           = prog.instr_valid && ready_c;
    assign load_entry_c     = prog.pen && (state inside {LDR_IDLE, LDR_BOOT, LDR_RUN});
    assign boot_start_c     = !prog.pen && (state inside {LDR_IDLE, LDR_LOAD, LDR_FULL});

    risc16_rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_stretch (
        .clk    (clk),
        .rst    (rst),
        .start  (boot_start_c),
        .zero_c (stretch_zero_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LDR_IDLE;
            ptr        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            checksum   <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            core_rst   <= 1'b1;
            loading    <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            // Accepted word: one write pulse next cycle, pointer wraps mod DEPTH
            if (xfer_c) begin
                imem_we    <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= prog.instr;
                ptr        <= ptr + ADDR_WIDTH'(1);
                word_count <= word_count + CNT_W'(1);
                checksum   <= checksum + prog.instr;
            end

            if (load_entry_c) begin
                state      <= LDR_LOAD;
                ptr        <= prog.base_addr;
                word_count <= '0;
                checksum   <= '0;
                full       <= 1'b0;
                overflow   <= 1'b0;
                core_rst   <= 1'b1;
                loading    <= 1'b1;
            end else if (boot_start_c) begin
                state    <= LDR_BOOT;
                core_rst <= 1'b1;
                loading  <= 1'b0;
            end else begin
                case (state)
                    LDR_LOAD: begin
                        if (xfer_c && (word_count == LAST_COUNT)) begin
                            state <= LDR_FULL;
                            full  <= 1'b1;
                        end
                    end
                    LDR_FULL: begin
                        if (prog.instr_valid) begin
                            overflow <= 1'b1;
                        end
                    end
                    LDR_BOOT: begin
                        if (stretch_zero_c) begin
                            state    <= LDR_RUN;
                            core_rst <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_risc16_prog_loader.sv
// Self-checking bench: two loaders (256-deep and 4-deep) share one directed
// stimulus stream and are compared every cycle against a behavioural model.
module tb_risc16_prog_loader;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_FULL = 2;
    localparam int PH_BOOT = 3;
    localparam int PH_RUN  = 4;
    localparam int RSTC    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pen;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  base_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc16_prog_loader_if #(.WORD_LENGTH(16), .ADDR_WIDTH(8)) if8 ();
    risc16_prog_loader_if #(.WORD_LENGTH(16), .ADDR_WIDTH(2)) if2 ();

    assign if8.pen         = pen;
    assign if8.instr       = instr;
    assign if8.instr_valid = instr_valid;
    assign if8.base_addr   = base_addr;
    assign if2.pen         = pen;
    assign if2.instr       = instr;
    assign if2.instr_valid = instr_valid;
    assign if2.base_addr   = base_addr[1:0];

    logic        we8, full8, ovf8, crst8, ld8;
    logic [7:0]  addr8;
    logic [15:0] wd8, cs8;
    logic [8:0]  wc8;
    logic        we2, full2, ovf2, crst2, ld2;
    logic [1:0]  addr2;
    logic [15:0] wd2, cs2;
    logic [2:0]  wc2;

    risc16_prog_loader #(.WORD_LENGTH(16), .ADDR_WIDTH(8), .RST_CYCLES(RSTC)) u_dut8 (
        .clk(clk), .rst(rst), .prog(if8.slave),
        .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
        .word_count(wc8), .checksum(cs8), .full(full8), .overflow(ovf8),
        .core_rst(crst8), .loading(ld8)
    );

    risc16_prog_loader #(.WORD_LENGTH(16), .ADDR_WIDTH(2), .RST_CYCLES(RSTC)) u_dut2 (
        .clk(clk), .rst(rst), .prog(if2.slave),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .word_count(wc2), .checksum(cs2), .full(full2), .overflow(ovf2),
        .core_rst(crst2), .loading(ld2)
    );

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: session phase, pointer, count, sum, pending write
    int m_ph[2], m_ptr[2], m_cnt[2], m_cs[2], m_ovf[2], m_boot[2];
    int m_we[2], m_addr[2], m_data[2];

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 4;
    endfunction

    function automatic void enter_load(input int d);
        m_ph[d]  = PH_LOAD;
        m_ptr[d] = int'(base_addr) % depth_of(d);
        m_cnt[d] = 0;
        m_cs[d]  = 0;
        m_ovf[d] = 0;
    endfunction

    function automatic void enter_boot(input int d);
        m_ph[d]   = PH_BOOT;
        m_boot[d] = RSTC;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ph[d] = PH_IDLE; m_ptr[d] = 0; m_cnt[d] = 0; m_cs[d] = 0;
                m_ovf[d] = 0; m_boot[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_data[d] = 0;
            end else begin
                m_we[d] = 0;
                if (pen && instr_valid && m_ph[d] == PH_LOAD) begin
                    m_we[d]   = 1;
                    m_addr[d] = m_ptr[d];
                    m_data[d] = int'(instr);
                    m_ptr[d]  = (m_ptr[d] + 1) % depth_of(d);
                    m_cnt[d]  = m_cnt[d] + 1;
                    m_cs[d]   = (m_cs[d] + int'(instr)) % 65536;
                end
                case (m_ph[d])
                    PH_IDLE: if (pen) enter_load(d); else enter_boot(d);
                    PH_LOAD: if (!pen) enter_boot(d);
                             else if (m_cnt[d] == depth_of(d)) m_ph[d] = PH_FULL;
                    PH_FULL: if (!pen) enter_boot(d);
                             else if (instr_valid) m_ovf[d] = 1;
                    PH_BOOT: if (pen) enter_load(d);
                             else if (m_boot[d] == 1) m_ph[d] = PH_RUN;
                             else m_boot[d] = m_boot[d] - 1;
                    default: if (pen) enter_load(d);
                endcase
            end
        end
    end

    task automatic cmp_dut(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] wc,
                           input logic [31:0] cs, input logic fl, input logic ovf,
                           input logic crst, input logic ld, input logic rdy);
        string p;
        p = (d == 0) ? "d8" : "d2";
        check({p, ".imem_we"}, 32'(we), m_we[d]);
        if (m_we[d] != 0) begin
            check({p, ".imem_addr"}, addr, m_addr[d]);
            check({p, ".imem_wdata"}, wdata, m_data[d]);
        end
        check({p, ".word_count"}, wc, m_cnt[d]);
        check({p, ".checksum"}, cs, m_cs[d]);
        check({p, ".full"}, 32'(fl), int'(m_cnt[d] == depth_of(d)));
        check({p, ".overflow"}, 32'(ovf), m_ovf[d]);
        check({p, ".core_rst"}, 32'(crst), int'(m_ph[d] != PH_RUN));
        check({p, ".loading"}, 32'(ld), int'(m_ph[d] == PH_LOAD || m_ph[d] == PH_FULL));
        check({p, ".instr_ready"}, 32'(rdy), int'(pen && m_ph[d] == PH_LOAD));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, we8, 32'(addr8), 32'(wd8), 32'(wc8), 32'(cs8), full8, ovf8, crst8, ld8,
                if8.instr_ready);
        cmp_dut(1, we2, 32'(addr2), 32'(wd2), 32'(wc2), 32'(cs2), full2, ovf2, crst2, ld2,
                if2.instr_ready);
    end

    task automatic drive(input logic p, input logic v, input logic [15:0] d);
        pen = p; instr_valid = v; instr = d;
        @(posedge clk); #1;
    endtask

    int exp_addr2[4] = '{3, 0, 1, 2};
    int hi;
    int nwe;

    initial begin
        rst = 1'b1; pen = 1'b1; instr_valid = 1'b0; instr = '0; base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.core_rst", 32'(crst8), 1);
        check("rst.imem_we", 32'(we8), 0);
        check("rst.imem_addr", 32'(addr8), 0);
        check("rst.imem_wdata", 32'(wd8), 0);
        check("rst.word_count", 32'(wc8), 0);
        check("rst.checksum", 32'(cs8), 0);
        check("rst.loading", 32'(ld8), 0);
        check("rst.instr_ready", 32'(if8.instr_ready), 0);
        rst = 1'b0;

        // Two-word load at base 0
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'h6B00);
        check("t1.addr0", 32'(addr8), 8'h00);
        check("t1.data0", 32'(wd8), 16'h6B00);
        drive(1'b1, 1'b1, 16'h6D00);
        check("t1.we1", 32'(we8), 1);
        check("t1.addr1", 32'(addr8), 8'h01);
        check("t1.data1", 32'(wd8), 16'h6D00);
        check("t1.word_count", 32'(wc8), 2);
        check("t1.checksum", 32'(cs8), 16'hD800);
        check("t1.core_rst", 32'(crst8), 1);

        // Reset stretch after pen falls
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 16'h0000);
            if (crst8 === 1'b1) hi++;
        end
        check("t2.core_rst_cycles", 32'(hi), 4);
        check("t2.core_rst_run", 32'(crst8), 0);
        check("t2.word_count_held", 32'(wc8), 2);
        check("t2.checksum_held", 32'(cs8), 16'hD800);

        // Wrap from base 3 on the 4-deep loader, then overflow
        base_addr = 8'd3;
        drive(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'(16'h1000 + i));
            check("t3.we", 32'(we2), 1);
            check("t3.addr", 32'(addr2), exp_addr2[i]);
        end
        check("t3.full", 32'(full2), 1);
        check("t3.word_count", 32'(wc2), 4);
        check("t3.ready_full", 32'(if2.instr_ready), 0);
        drive(1'b1, 1'b1, 16'h1004);
        check("t3.overflow", 32'(ovf2), 1);
        check("t3.no_write", 32'(we2), 0);
        check("t3.d8_count", 32'(wc8), 5);
        check("t3.d8_addr", 32'(addr8), 7);

        // pen drops with valid held high
        drive(1'b0, 1'b0, 16'h0000);
        base_addr = 8'h10;
        drive(1'b1, 1'b0, 16'h0000);
        nwe = 0;
        drive(1'b1, 1'b1, 16'hA001); nwe += int'(we8);
        drive(1'b1, 1'b1, 16'hB002); nwe += int'(we8);
        check("t4.addr_last", 32'(addr8), 8'h11);
        drive(1'b0, 1'b1, 16'hC003); nwe += int'(we8);
        drive(1'b0, 1'b1, 16'hD004); nwe += int'(we8);
        check("t4.write_pulses", 32'(nwe), 2);
        check("t4.word_count", 32'(wc8), 2);

        // Checksum wrap, restart from BOOT
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'hFFFF);
        drive(1'b1, 1'b1, 16'h0002);
        check("t5.checksum", 32'(cs8), 16'h0001);
        check("t5.checksum_d2", 32'(cs2), 16'h0001);
        check("t5.overflow_cleared", 32'(ovf2), 0);

        // Async reset with a pulse in flight and another transfer pending
        drive(1'b1, 1'b1, 16'h1111);
        check("t6.pulse_before", 32'(we8), 1);
        #2 rst = 1'b1;
        #1;
        check("t6.we_dropped", 32'(we8), 0);
        check("t6.addr", 32'(addr8), 0);
        check("t6.word_count", 32'(wc8), 0);
        check("t6.checksum", 32'(cs8), 0);
        check("t6.core_rst", 32'(crst8), 1);
        check("t6.loading", 32'(ld8), 0);
        check("t6.ready", 32'(if8.instr_ready), 0);
        @(posedge clk); #1;
        check("t6.we_held_off", 32'(we8), 0);
        base_addr = 8'h20;
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'h55AA);
        check("t6.reload_addr", 32'(addr8), 8'h20);
        check("t6.reload_count", 32'(wc8), 1);
        check("t6.reload_sum", 32'(cs8), 16'h55AA);

        repeat (6) drive(1'b0, 1'b0, 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
